// File: rtl/program_loader.sv
// Boot loader: turns a length-prefixed byte stream into 16-bit instruction-memory writes
// and holds the CPU in reset until a load finishes with a matching XOR checksum.
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk_pi,
  input  logic                  reset_pi,
  input  logic                  start_pi,
  input  logic                  byte_valid_pi,
  input  logic [7:0]            byte_data_pi,
  output logic                  byte_ready_po,
  output logic                  imem_wr_en_po,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr_po,
  output logic [15:0]           imem_wr_data_po,
  output logic                  cpu_reset_po,
  output logic                  busy_po,
  output logic                  done_po,
  output logic                  error_po
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  // The timer only needs to reach TIMEOUT_CYCLES-1: the next idle cycle is the expiry edge.
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int          CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int          CNT_LIM    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned MAX_LEN    = 32'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            lenLo_q;
  logic [7:0]            loByte_q;
  logic [7:0]            xor_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      timer_q;

  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpuReset_q, cpuReset_d;
  logic                  wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [15:0]           wrData_q;

  logic                  accept;
  logic                  startTake;
  logic                  timeoutHit;
  logic                  lenBad;
  logic                  lastWord;
  logic [15:0]           lenFull;

  assign accept     = byte_valid_pi & ready_q;
  assign startTake  = start_pi & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign timeoutHit = TIMEOUT_EN & ready_q & ~accept & (timer_q == CNT_W'(CNT_LIM));
  assign lenFull    = {byte_data_pi, lenLo_q};
  assign lenBad     = (lenFull == 16'd0) | (32'(lenFull) > MAX_LEN);
  assign lastWord   = (remaining_q == (ADDR_WIDTH + 1)'(1));

  // State and every output are registered; outputs are decoded from the next state.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpuReset_q <= 1'b1;
      wrEn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpuReset_q <= cpuReset_d;
      wrEn_q     <= wrEn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (startTake) state_d = S_LEN_LO;
      S_LEN_LO:  if (accept) state_d = S_LEN_HI;
      S_LEN_HI:  if (accept) state_d = lenBad ? S_ERROR : S_DATA_LO;
      S_DATA_LO: if (accept) state_d = S_DATA_HI;
      S_DATA_HI: if (accept) state_d = lastWord ? S_CHECK : S_DATA_LO;
      S_CHECK:   if (accept) state_d = (byte_data_pi == xor_q) ? S_DONE : S_ERROR;
      default:   state_d = S_IDLE;
    endcase
    // An accept on the expiry cycle keeps the load alive, so timeoutHit already excludes it.
    if (timeoutHit) state_d = S_ERROR;
  end

  always_comb begin
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    cpuReset_d = 1'b1;
    wrEn_d     = accept & (state_q == S_DATA_HI);
    unique case (state_d)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        done_d     = 1'b1;
        cpuReset_d = 1'b0;
      end
      S_ERROR: error_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length, byte assembly, running checksum, address and idle timer.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      lenLo_q     <= '0;
      loByte_q    <= '0;
      xor_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      timer_q     <= '0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
    end else if (startTake) begin
      xor_q   <= '0;
      addr_q  <= '0;
      timer_q <= '0;
    end else if (ready_q) begin
      if (accept) begin
        timer_q <= '0;
      end else if (TIMEOUT_EN) begin
        timer_q <= timer_q + CNT_W'(1);
      end
      if (accept) begin
        if (state_q != S_CHECK) xor_q <= xor_q ^ byte_data_pi;
        unique case (state_q)
          S_LEN_LO:  lenLo_q <= byte_data_pi;
          S_LEN_HI:  remaining_q <= lenFull[ADDR_WIDTH:0];
          S_DATA_LO: loByte_q <= byte_data_pi;
          S_DATA_HI: begin
            wrAddr_q    <= addr_q;
            wrData_q    <= {byte_data_pi, loByte_q};
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - (ADDR_WIDTH + 1)'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready_po   = ready_q;
  assign busy_po         = busy_q;
  assign done_po         = done_q;
  assign error_po        = error_q;
  assign cpu_reset_po    = cpuReset_q;
  assign imem_wr_en_po   = wrEn_q;
  assign imem_wr_addr_po = wrAddr_q;
  assign imem_wr_data_po = wrData_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad checksum, bad lengths, idle timeout and
// reset in the middle of a load, with expected values worked out by hand.
module tb_program_loader;

  logic       clk_pi = 1'b0;
  logic       reset_pi = 1'b1;
  logic       start_pi = 1'b0;
  logic       byte_valid_pi = 1'b0;
  logic [7:0] byte_data_pi = 8'h00;
  logic       byte_ready_po;
  logic       imem_wr_en_po;
  logic [7:0] imem_wr_addr_po;
  logic [15:0] imem_wr_data_po;
  logic       cpu_reset_po;
  logic       busy_po;
  logic       done_po;
  logic       error_po;

  int errorCount = 0;
  int checkCount = 0;
  int wrCount = 0;
  int wrBase;

  program_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_pi(clk_pi),
    .reset_pi(reset_pi),
    .start_pi(start_pi),
    .byte_valid_pi(byte_valid_pi),
    .byte_data_pi(byte_data_pi),
    .byte_ready_po(byte_ready_po),
    .imem_wr_en_po(imem_wr_en_po),
    .imem_wr_addr_po(imem_wr_addr_po),
    .imem_wr_data_po(imem_wr_data_po),
    .cpu_reset_po(cpu_reset_po),
    .busy_po(busy_po),
    .done_po(done_po),
    .error_po(error_po)
  );

  always #5 clk_pi = ~clk_pi;

  // Every strobe cycle is counted, so a strobe held two cycles shows up as an extra write.
  always @(negedge clk_pi) begin
    if (imem_wr_en_po === 1'b1) wrCount <= wrCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_pi);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic startLoad();
    start_pi = 1'b1;
    tick();
    start_pi = 1'b0;
    checkOutput("start_busy", 32'(busy_po), 32'd1);
    checkOutput("start_cpurst", 32'(cpu_reset_po), 32'd1);
    checkOutput("start_done_clr", 32'(done_po), 32'd0);
    checkOutput("start_err_clr", 32'(error_po), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    idle(gap);
    checkOutput("ready", 32'(byte_ready_po), 32'd1);
    byte_valid_pi = 1'b1;
    byte_data_pi  = b;
    tick();
    byte_valid_pi = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] addr, input logic [15:0] w, input int gap);
    applyStimulus(w[7:0], gap);
    applyStimulus(w[15:8], gap);
    checkOutput("wr_en", 32'(imem_wr_en_po), 32'd1);
    checkOutput("wr_addr", 32'(imem_wr_addr_po), 32'(addr));
    checkOutput("wr_data", 32'(imem_wr_data_po), 32'(w));
  endtask

  initial begin
    // Reset held for three cycles
    idle(3);
    checkOutput("rst_cpurst", 32'(cpu_reset_po), 32'd1);
    checkOutput("rst_ready", 32'(byte_ready_po), 32'd0);
    checkOutput("rst_wren", 32'(imem_wr_en_po), 32'd0);
    checkOutput("rst_busy", 32'(busy_po), 32'd0);
    checkOutput("rst_done", 32'(done_po), 32'd0);
    checkOutput("rst_error", 32'(error_po), 32'd0);
    reset_pi = 1'b0;
    idle(2);

    // Good two-word load
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    sendWord(8'd0, 16'h1234, 0);
    sendWord(8'd1, 16'h5678, 0);
    checkOutput("hold_addr", 32'(imem_wr_addr_po), 32'd1);
    applyStimulus(8'h0A, 0);
    checkOutput("good_done", 32'(done_po), 32'd1);
    checkOutput("good_cpurst", 32'(cpu_reset_po), 32'd0);
    checkOutput("good_busy", 32'(busy_po), 32'd0);
    checkOutput("good_error", 32'(error_po), 32'd0);
    checkOutput("good_ready", 32'(byte_ready_po), 32'd0);
    checkOutput("good_wrcount", 32'(wrCount - wrBase), 32'd2);
    idle(20);
    checkOutput("good_sticky", 32'(done_po), 32'd1);

    // Same stream, wrong checksum
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h02, 0);
    applyStimulus(8'h00, 0);
    sendWord(8'd0, 16'h1234, 0);
    sendWord(8'd1, 16'h5678, 0);
    applyStimulus(8'h0B, 0);
    checkOutput("bad_error", 32'(error_po), 32'd1);
    checkOutput("bad_cpurst", 32'(cpu_reset_po), 32'd1);
    checkOutput("bad_done", 32'(done_po), 32'd0);
    checkOutput("bad_wrcount", 32'(wrCount - wrBase), 32'd2);

    // Zero length and oversize length (257)
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0);
    checkOutput("len0_error", 32'(error_po), 32'd1);
    checkOutput("len0_ready", 32'(byte_ready_po), 32'd0);
    startLoad();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    checkOutput("len257_error", 32'(error_po), 32'd1);
    checkOutput("len257_busy", 32'(busy_po), 32'd0);
    idle(3);
    checkOutput("len_wrcount", 32'(wrCount - wrBase), 32'd0);

    // Stall after a low data byte: error exactly 16 cycles after that accept
    startLoad();
    applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(8'h55, 0);
    idle(15);
    checkOutput("to_before", 32'(error_po), 32'd0);
    tick();
    checkOutput("to_at16", 32'(error_po), 32'd1);
    checkOutput("to_ready", 32'(byte_ready_po), 32'd0);

    // Gaps of 15 idle cycles: each accept lands on the expiry cycle and must win
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h02, 15);
    applyStimulus(8'h00, 15);
    sendWord(8'd0, 16'h2211, 15);
    sendWord(8'd1, 16'h4433, 15);
    applyStimulus(8'h46, 15);
    checkOutput("gap_error", 32'(error_po), 32'd0);
    checkOutput("gap_done", 32'(done_po), 32'd1);
    checkOutput("gap_wrcount", 32'(wrCount - wrBase), 32'd2);

    // Reset during a 4-word load, coincident with the second word's high byte
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h04, 0);
    applyStimulus(8'h00, 0);
    sendWord(8'd0, 16'h0102, 0);
    applyStimulus(8'h04, 0);
    reset_pi = 1'b1;
    applyStimulus(8'h03, 0);
    reset_pi = 1'b0;
    checkOutput("mid_wren", 32'(imem_wr_en_po), 32'd0);
    checkOutput("mid_busy", 32'(busy_po), 32'd0);
    checkOutput("mid_ready", 32'(byte_ready_po), 32'd0);
    checkOutput("mid_cpurst", 32'(cpu_reset_po), 32'd1);
    idle(20);
    checkOutput("mid_error", 32'(error_po), 32'd0);
    checkOutput("mid_wrcount", 32'(wrCount - wrBase), 32'd1);

    // Fresh full load after the reset
    wrBase = wrCount;
    startLoad();
    applyStimulus(8'h04, 0);
    applyStimulus(8'h00, 0);
    sendWord(8'd0, 16'hA001, 0);
    sendWord(8'd1, 16'hB002, 0);
    sendWord(8'd2, 16'hC003, 0);
    sendWord(8'd3, 16'hD004, 0);
    applyStimulus(8'h00, 0);
    checkOutput("reload_done", 32'(done_po), 32'd1);
    checkOutput("reload_cpurst", 32'(cpu_reset_po), 32'd0);
    checkOutput("reload_wrcount", 32'(wrCount - wrBase), 32'd4);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
